// File: rtl/ram_fake_pkg.sv
// Shared types and helpers for the fake-memory arbiter: response entry layout,
// requester-id width and the byte-lane merge used by partial writes.
package ram_fake_pkg;

    localparam int RF_ADDR_W   = 32;
    localparam int RF_DATA_W   = 32;
    localparam int RF_TAG_W    = 8;
    localparam int RF_MAX_REQS = 4;
    localparam int RF_MERGE_W  = 64;
    localparam int RF_MERGE_BE = RF_MERGE_W / 8;

    function automatic int req_id_w(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    // Layout of one buffered read response, sized for the default configuration.
    typedef struct packed {
        logic [$clog2(RF_MAX_REQS)-1:0] id;
        logic [RF_TAG_W-1:0]            tag;
        logic [RF_DATA_W-1:0]           data;
    } rsp_entry_t;

    // Lanes with byteen set take the new data; the rest keep the stored word.
    function automatic logic [RF_MERGE_W-1:0] merge_bytes(
        input logic [RF_MERGE_W-1:0]  wdata,
        input logic [RF_MERGE_W-1:0]  old_word,
        input logic [RF_MERGE_BE-1:0] byteen
    );
        logic [RF_MERGE_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < RF_MERGE_BE; b++) begin
            if (byteen[b]) begin
                merged[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_fake_rsp_fifo.sv
// Ordered response buffer: synchronous FIFO with async active-low reset that
// exposes the head entry combinationally.
module ram_fake_rsp_fifo
    import ram_fake_pkg::*;
#(
    parameter int WIDTH = RF_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ram_fake_mem_arbiter.sv
// Round-robin arbiter sharing one fake-memory word port between requesters;
// partial writes merge with the current word, reads return in grant order.
module ram_fake_mem_arbiter
    import ram_fake_pkg::*;
#(
    parameter int NUM_REQS  = 2,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int DATA_W    = RF_DATA_W,
    parameter int TAG_W     = RF_TAG_W,
    parameter int RSP_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQS-1:0]                 req_valid,
    input  logic [NUM_REQS-1:0]                 req_rw,
    input  logic [NUM_REQS-1:0][DATA_W/8-1:0]   req_byteen,
    input  logic [NUM_REQS-1:0][ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQS-1:0][DATA_W-1:0]     req_data,
    input  logic [NUM_REQS-1:0][TAG_W-1:0]      req_tag,
    output logic [NUM_REQS-1:0]                 req_ready,
    output logic [NUM_REQS-1:0]                 rsp_valid,
    output logic [DATA_W-1:0]                   rsp_data,
    output logic [TAG_W-1:0]                    rsp_tag,
    input  logic [NUM_REQS-1:0]                 rsp_ready,
    output logic [ADDR_W-1:0]                   bk_addr,
    output logic                                bk_wen,
    output logic [DATA_W-1:0]                   bk_wdata,
    input  logic [DATA_W-1:0]                   bk_rdata,
    input  logic                                bk_oob,
    output logic                                oob_err,
    output logic                                busy
);

    localparam int ID_W    = req_id_w(NUM_REQS);
    localparam int ENTRY_W = ID_W + TAG_W + DATA_W;

    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic                oob_err_q, oob_err_d;
    logic [NUM_REQS-1:0] eligible;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_id;
    logic                write_grant;
    logic                read_grant;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic [ID_W-1:0]     head_id;
    logic [TAG_W-1:0]    head_tag;
    logic [DATA_W-1:0]   head_data;

    // A read needs a free FIFO slot at grant time; a same-cycle pop does not count.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = rst_n & req_valid[i] & (req_rw[i] | ~fifo_full);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            if (!grant_vld && eligible[(int'(last_grant_q) + k) % NUM_REQS]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'((int'(last_grant_q) + k) % NUM_REQS);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready = NUM_REQS'(1) << grant_id;
        end
    end

    assign write_grant = grant_vld & req_rw[grant_id];
    assign read_grant  = grant_vld & ~req_rw[grant_id];

    always_comb begin
        bk_addr  = grant_vld ? req_addr[grant_id] : req_addr[0];
        bk_wen   = write_grant & ~bk_oob;
        bk_wdata = DATA_W'(merge_bytes(RF_MERGE_W'(req_data[grant_id]),
                                       RF_MERGE_W'(bk_rdata),
                                       RF_MERGE_BE'(req_byteen[grant_id])));
    end

    // Out-of-bounds reads still complete, with zero data, so the requester is not stranded.
    always_comb begin
        fifo_push  = read_grant;
        push_entry = {grant_id, req_tag[grant_id], (bk_oob ? {DATA_W{1'b0}} : bk_rdata)};
    end

    always_comb begin
        last_grant_d = grant_vld ? grant_id : last_grant_q;
        oob_err_d    = oob_err_q | (grant_vld & bk_oob);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= ID_W'(NUM_REQS - 1);
            oob_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            oob_err_q    <= oob_err_d;
        end
    end

    ram_fake_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    // Only the head's owner sees rsp_valid, so other requesters wait behind it.
    always_comb begin
        {head_id, head_tag, head_data} = head_entry;
        rsp_valid = '0;
        if (rst_n && !fifo_empty) begin
            rsp_valid = NUM_REQS'(1) << head_id;
        end
        fifo_pop = |(rsp_valid & rsp_ready);
        rsp_data = fifo_empty ? '0 : head_data;
        rsp_tag  = fifo_empty ? '0 : head_tag;
    end

    assign oob_err = oob_err_q;
    assign busy    = (|req_valid) | ~fifo_empty;

endmodule

// File: tb/tb_ram_fake_mem_arbiter.sv
// Directed bench for ram_fake_mem_arbiter with a 16-word fake backend at 0x80000000
// and a scoreboard of expected read responses.
module tb_ram_fake_mem_arbiter;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
    logic [1:0][3:0]   req_byteen;
    logic [1:0][31:0]  req_addr, req_data;
    logic [1:0][7:0]   req_tag;
    logic [31:0]       rsp_data, bk_addr, bk_wdata, bk_rdata;
    logic [7:0]        rsp_tag;
    logic              bk_wen, bk_oob, oob_err, busy;

    int checks = 0;
    int errors = 0;
    int exp_last;

    typedef struct {
        int          id;
        logic [7:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];

    ram_fake_mem_arbiter #(
        .NUM_REQS (2), .ADDR_W (32), .DATA_W (32), .TAG_W (8), .RSP_DEPTH (4)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_rw (req_rw), .req_byteen (req_byteen),
        .req_addr (req_addr), .req_data (req_data), .req_tag (req_tag),
        .req_ready (req_ready), .rsp_valid (rsp_valid), .rsp_data (rsp_data),
        .rsp_tag (rsp_tag), .rsp_ready (rsp_ready), .bk_addr (bk_addr),
        .bk_wen (bk_wen), .bk_wdata (bk_wdata), .bk_rdata (bk_rdata),
        .bk_oob (bk_oob), .oob_err (oob_err), .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'hDEADBEEF;
        if (i == 3) return 32'h11223344;
        return 32'hC0DE0000 | i;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] nw, input logic [31:0] old,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (nw & mask) | (old & ~mask);
    endfunction

    // Fake backend: combinational read, write at the clock edge, reloaded during reset.
    always_comb begin
        bk_oob   = (bk_addr[31:4] != 28'h8000000);
        bk_rdata = bk_oob ? 32'hBAD0BAD0 : mem[bk_addr[3:0]];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (bk_wen) begin
            mem[bk_addr[3:0]] <= bk_wdata;
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        exp_last = 1;
    endtask

    // One request from a single requester, checked during its grant cycle.
    task automatic issue(input int id, input logic rw, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be, input logic [7:0] tag);
        logic oob;
        int   idx;
        exp_t e;
        req_valid          = '0;
        req_valid[id]      = 1'b1;
        req_rw[id]         = rw;
        req_addr[id]       = addr;
        req_data[id]       = data;
        req_byteen[id]     = be;
        req_tag[id]        = tag;
        #2;
        oob = (addr[31:4] != 28'h8000000);
        idx = int'(addr[3:0]);
        check("grant", 64'(req_ready), 64'(1) << id);
        if (rw) begin
            check("bk_wen", 64'(bk_wen), 64'(!oob));
            if (!oob) begin
                check("bk_wdata", 64'(bk_wdata), 64'(ref_merge(data, ref_mem[idx], be)));
                ref_mem[idx] = ref_merge(data, ref_mem[idx], be);
            end
        end else begin
            e.id   = id;
            e.tag  = tag;
            e.data = oob ? 32'h0 : ref_mem[idx];
            exp_q.push_back(e);
        end
        exp_last = id;
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid & rsp_ready), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_valid & rsp_ready), 64'(1) << e.id);
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        exp_t e;
        ref_init();
        req_valid  = 2'b11;
        req_rw     = 2'b10;
        req_byteen = '1;
        req_addr   = {32'h80000001, 32'h80000000};
        req_data   = '0;
        req_tag    = '0;
        rsp_ready  = 2'b11;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_bk_wen", 64'(bk_wen), 64'(0));
        check("rst_oob_err", 64'(oob_err), 64'(0));
        req_valid = '0;
        req_rw    = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_rsp_data", 64'(rsp_data), 64'(0));
        check("idle_rsp_tag", 64'(rsp_tag), 64'(0));
        @(posedge clk); #1;

        // Single read: response visible the cycle after the grant.
        check("pre_rsp_valid", 64'(rsp_valid), 64'(0));
        issue(0, 1'b0, 32'h80000000, 32'h0, 4'h0, 8'd5);
        check("rd_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        check("rd_rsp_data", 64'(rsp_data), 64'(32'hDEADBEEF));
        check("rd_rsp_tag", 64'(rsp_tag), 64'(8'd5));
        @(posedge clk); #1;

        // Both requesters reading continuously: grants rotate.
        req_valid = 2'b11;
        req_rw    = 2'b00;
        for (int k = 0; k < 4; k++) begin
            req_addr[0] = 32'h80000008 + k;
            req_addr[1] = 32'h8000000C + k;
            req_tag[0]  = 8'h10 + 8'(k);
            req_tag[1]  = 8'h20 + 8'(k);
            #2;
            w = (exp_last + 1) % 2;
            check("rr_grant", 64'(req_ready), 64'(1) << w);
            e.id   = w;
            e.tag  = req_tag[w];
            e.data = ref_mem[req_addr[w][3:0]];
            exp_q.push_back(e);
            exp_last = w;
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (3) @(posedge clk); #1;

        // Partial and empty byte-enable writes, each followed by a read-back.
        issue(0, 1'b1, 32'h80000003, 32'hAABBCCDD, 4'b0101, 8'd0);
        issue(0, 1'b0, 32'h80000003, 32'h0, 4'h0, 8'd7);
        issue(1, 1'b1, 32'h80000003, 32'h00000000, 4'b0000, 8'd0);
        issue(1, 1'b0, 32'h80000003, 32'h0, 4'h0, 8'd8);
        repeat (3) @(posedge clk); #1;

        // Fill the FIFO with responses held back; reads stall, a write still passes.
        rsp_ready = 2'b00;
        issue(0, 1'b0, 32'h80000001, 32'h0, 4'h0, 8'h31);
        issue(1, 1'b0, 32'h80000002, 32'h0, 4'h0, 8'h32);
        issue(0, 1'b0, 32'h80000004, 32'h0, 4'h0, 8'h33);
        issue(1, 1'b0, 32'h80000005, 32'h0, 4'h0, 8'h34);
        req_valid   = 2'b11;
        req_rw      = 2'b10;
        req_addr[0] = 32'h80000006;
        req_addr[1] = 32'h80000007;
        req_data[1] = 32'h55AA55AA;
        req_byteen[1] = 4'hF;
        #2;
        check("full_wr_grant", 64'(req_ready), 64'(2'b10));
        check("full_bk_wen", 64'(bk_wen), 64'(1));
        ref_mem[7] = 32'h55AA55AA;
        exp_last = 1;
        @(posedge clk); #1;
        req_valid = 2'b01;
        #2;
        check("full_rd_stall", 64'(req_ready), 64'(0));
        check("full_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 2'b11;
        repeat (6) @(posedge clk); #1;
        check("drain_count", 64'(exp_q.size()), 64'(0));
        issue(0, 1'b0, 32'h80000007, 32'h0, 4'h0, 8'h35);
        repeat (2) @(posedge clk); #1;

        // Out-of-bounds read and write.
        issue(0, 1'b0, 32'h00000010, 32'h0, 4'h0, 8'd9);
        check("oob_err_set", 64'(oob_err), 64'(1));
        issue(1, 1'b1, 32'h00000020, 32'hFFFFFFFF, 4'hF, 8'd0);
        repeat (2) @(posedge clk); #1;
        check("oob_err_sticky", 64'(oob_err), 64'(1));

        // Reset with responses queued: everything in flight is dropped.
        rsp_ready = 2'b00;
        issue(0, 1'b0, 32'h80000001, 32'h0, 4'h0, 8'h41);
        issue(1, 1'b0, 32'h80000002, 32'h0, 4'h0, 8'h42);
        issue(0, 1'b0, 32'h80000004, 32'h0, 4'h0, 8'h43);
        check("pre_rst_valid", 64'(rsp_valid), 64'(2'b01));
        req_valid = 2'b11;
        req_rw    = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(0));
        exp_q.delete();
        ref_init();
        repeat (2) @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b1;
        #1;
        check("post_rst_oob_err", 64'(oob_err), 64'(0));
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_rsp_data", 64'(rsp_data), 64'(0));
        @(posedge clk); #1;
        rsp_ready   = 2'b11;
        req_valid   = 2'b11;
        req_addr[0] = 32'h80000000;
        req_addr[1] = 32'h80000003;
        req_tag[0]  = 8'h51;
        req_tag[1]  = 8'h52;
        #2;
        check("post_rst_first", 64'(req_ready), 64'(2'b01));
        e.id = 0; e.tag = 8'h51; e.data = ref_mem[0];
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 2'b10;
        #2;
        check("post_rst_second", 64'(req_ready), 64'(2'b10));
        e.id = 1; e.tag = 8'h52; e.data = ref_mem[3];
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk); #1;
        check("final_scoreboard", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
